trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_if.sv | 36 +++
 rtl/trap_ctrl.sv | 121 ++++++++++++
 tb/tb_trap_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Trap controller bundle: commit, memory drain, CSR command and
// fetch redirect signals shared between trap_ctrl and its neighbours.
interface trap_ctrl_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [63:0] commit_pc;
  logic        commit_ecall;
  logic        commit_mret;
  logic        mem_busy;
  logic        csr_ecall;
  logic        csr_mret;
  logic [63:0] csr_pc;
  logic [63:0] csr_next_pc;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [63:0] redirect_pc;
  logic [31:0] trap_count;
  logic        drain_error;

  modport master (
    input  commit_valid, commit_pc, commit_ecall, commit_mret,
    input  mem_busy, csr_next_pc, redirect_ready,
    output commit_ready, csr_ecall, csr_mret, csr_pc,
    output flush, redirect_valid, redirect_pc,
    output trap_count, drain_error
  );

  modport slave (
    output commit_valid, commit_pc, commit_ecall, commit_mret,
    output mem_busy, csr_next_pc, redirect_ready,
    input  commit_ready, csr_ecall, csr_mret, csr_pc,
    input  flush, redirect_valid, redirect_pc,
    input  trap_count, drain_error
  );
endinterface

// File: rtl/trap_ctrl.sv
// Commit-side trap sequencer: drain memory, issue ecall/mret to the
// CSR file, then hand the CSR target PC to fetch as a redirect.
module trap_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  trap_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, DRAIN, ISSUE, REDIRECT
  } state_e;

  localparam logic [7:0] LAST = 8'(DRAIN_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kind_q, kind_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic        err_q, err_d;
  logic [63:0] rpc_q, rpc_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        ecall_q, ecall_d;
  logic        mret_q, mret_d;
  logic        flush_q, flush_d;
  logic        rv_q, rv_d;

  logic is_trap;
  assign is_trap = bus.commit_ecall | bus.commit_mret;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kind_d      = kind_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    rpc_d       = rpc_q;
    tcnt_d      = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.commit_valid && is_trap) begin
          pc_d        = bus.commit_pc;
          kind_d      = bus.commit_ecall;
          drain_cnt_d = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 8'd1;
        if (!bus.mem_busy) begin
          state_d = ISSUE;
        end else if (drain_cnt_q == LAST) begin
          err_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rpc_d = {bus.csr_next_pc[63:2], 2'b00};
        if (tcnt_q != 32'hFFFF_FFFF) begin
          tcnt_d = tcnt_q + 32'd1;
        end
        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command/redirect/flush flops decode the next state so they are
  // registered yet line up with the state they belong to.
  always_comb begin
    ecall_d = (state_d == ISSUE) && kind_d;
    mret_d  = (state_d == ISSUE) && !kind_d;
    flush_d = (state_d != IDLE);
    rv_d    = (state_d == REDIRECT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      kind_q      <= 1'b0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      rpc_q       <= '0;
      tcnt_q      <= '0;
      ecall_q     <= 1'b0;
      mret_q      <= 1'b0;
      flush_q     <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kind_q      <= kind_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      rpc_q       <= rpc_d;
      tcnt_q      <= tcnt_d;
      ecall_q     <= ecall_d;
      mret_q      <= mret_d;
      flush_q     <= flush_d;
      rv_q        <= rv_d;
    end
  end

  assign bus.commit_ready   = (state_q == IDLE);
  assign bus.csr_ecall      = ecall_q;
  assign bus.csr_mret       = mret_q;
  assign bus.csr_pc         = pc_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.trap_count     = tcnt_q;
  assign bus.drain_error    = err_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: the driver queues expected commands
// and redirects, a negedge monitor pops and compares them.
module tb_trap_ctrl;

  localparam int TO = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  logic rv_prev = 1'b0;

  typedef struct {
    logic [1:0]  kind;
    logic [63:0] pc;
    int          cyc;
  } iss_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] cnt;
    int          cyc;
  } red_t;

  iss_t isq[$];
  red_t rsq[$];

  trap_ctrl_if tif ();

  trap_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 1000) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Monitor: samples shortly after the negedge, once driver updates settle.
  always @(negedge clk) begin
    iss_t e;
    red_t r;
    #2;
    if (!reset) begin
      if (tif.csr_ecall || tif.csr_mret) begin
        if (isq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cmd: got %b%b expected none",
                   tif.csr_ecall, tif.csr_mret);
        end else begin
          e = isq.pop_front();
          check("cmd_kind", {62'd0, tif.csr_ecall, tif.csr_mret},
                {62'd0, e.kind});
          check("cmd_pc", tif.csr_pc, e.pc);
          check("cmd_cyc", 64'(cyc), 64'(e.cyc));
          check("cmd_flush", {63'd0, tif.flush}, 64'd1);
        end
      end
      if (tif.redirect_valid) begin
        if (rsq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_redirect: got %0h expected none",
                   tif.redirect_pc);
        end else begin
          r = rsq[0];
          if (!rv_prev) check("rd_cyc", 64'(cyc), 64'(r.cyc));
          check("rd_pc", tif.redirect_pc, r.pc);
          check("rd_cnt", {32'd0, tif.trap_count}, {32'd0, r.cnt});
          check("rd_flush", {63'd0, tif.flush}, 64'd1);
          if (tif.redirect_ready) void'(rsq.pop_front());
        end
      end
      rv_prev = tif.redirect_valid;
    end else begin
      rv_prev = 1'b0;
    end
  end

  task automatic run_trap(input logic [63:0] pc,
                          input logic ec,
                          input logic mr,
                          input logic [63:0] npc,
                          input int busy,
                          input int d,
                          input logic exp_err);
    int acc;
    int off;
    iss_t e;
    red_t r;
    @(negedge clk);
    off = (busy >= TO) ? 1 + TO : 2 + busy;
    acc = cyc;
    exp_cnt++;
    e.kind = ec ? 2'b10 : 2'b01;
    e.pc   = pc;
    e.cyc  = acc + off;
    isq.push_back(e);
    r.pc  = {npc[63:2], 2'b00};
    r.cnt = 32'(exp_cnt);
    r.cyc = acc + off + 1;
    rsq.push_back(r);
    tif.commit_valid   = 1'b1;
    tif.commit_pc      = pc;
    tif.commit_ecall   = ec;
    tif.commit_mret    = mr;
    tif.mem_busy       = (busy > 0);
    tif.csr_next_pc    = npc;
    tif.redirect_ready = (d == 0);
    @(negedge clk);
    tif.commit_valid = 1'b0;
    tif.commit_ecall = 1'b0;
    tif.commit_mret  = 1'b0;
    check("drain_flush", {63'd0, tif.flush}, 64'd1);
    check("drain_ready", {63'd0, tif.commit_ready}, 64'd0);
    repeat (busy) @(negedge clk);
    tif.mem_busy = 1'b0;
    wait_cyc(acc + off + 1);
    tif.csr_next_pc = 64'hDEAD_BEEF_0BAD_F00D;
    for (int i = 0; i < d; i++) begin
      tif.commit_valid = 1'b1;
      tif.commit_ecall = 1'b1;
      check("bp_ready", {63'd0, tif.commit_ready}, 64'd0);
      check("bp_flush", {63'd0, tif.flush}, 64'd1);
      @(negedge clk);
    end
    tif.redirect_ready = 1'b1;
    tif.commit_valid   = 1'b0;
    tif.commit_ecall   = 1'b0;
    @(negedge clk);
    tif.redirect_ready = 1'b0;
    check("idle_ready", {63'd0, tif.commit_ready}, 64'd1);
    check("idle_cyc", 64'(cyc), 64'(acc + off + 2 + d));
    check("idle_flush", {63'd0, tif.flush}, 64'd0);
    check("drain_error", {63'd0, tif.drain_error}, {63'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.commit_valid   = 1'b0;
    tif.commit_pc      = '0;
    tif.commit_ecall   = 1'b0;
    tif.commit_mret    = 1'b0;
    tif.mem_busy       = 1'b0;
    tif.csr_next_pc    = '0;
    tif.redirect_ready = 1'b0;
    #1;
    check("rst_ready", {63'd0, tif.commit_ready}, 64'd1);
    check("rst_flush", {63'd0, tif.flush}, 64'd0);
    check("rst_cmd", {62'd0, tif.csr_ecall, tif.csr_mret}, 64'd0);
    check("rst_rv", {63'd0, tif.redirect_valid}, 64'd0);
    check("rst_csr_pc", tif.csr_pc, 64'd0);
    check("rst_rd_pc", tif.redirect_pc, 64'd0);
    check("rst_cnt", {32'd0, tif.trap_count}, 64'd0);
    check("rst_err", {63'd0, tif.drain_error}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // plain commit: accepted, nothing happens
    @(negedge clk);
    tif.commit_valid = 1'b1;
    tif.commit_pc    = 64'h100;
    @(negedge clk);
    tif.commit_valid = 1'b0;
    check("plain_ready", {63'd0, tif.commit_ready}, 64'd1);
    check("plain_flush", {63'd0, tif.flush}, 64'd0);

    run_trap(64'h8000_0100, 1'b1, 1'b0, 64'h8000_0004, 0, 0, 1'b0);
    run_trap(64'h8000_0200, 1'b0, 1'b1, 64'h8000_0100, 4, 0, 1'b0);
    run_trap(64'h3000, 1'b1, 1'b0, 64'h3100, TO, 0, 1'b1);
    run_trap(64'h4000, 1'b0, 1'b1, 64'h5008, 0, 3, 1'b1);
    run_trap(64'h6000, 1'b1, 1'b1, 64'h1003, 1, 0, 1'b1);

    // async reset during DRAIN abandons the trap
    @(negedge clk);
    tif.commit_valid = 1'b1;
    tif.commit_ecall = 1'b1;
    tif.commit_pc    = 64'h7000;
    tif.mem_busy     = 1'b1;
    @(negedge clk);
    tif.commit_valid = 1'b0;
    tif.commit_ecall = 1'b0;
    check("ar_flush_pre", {63'd0, tif.flush}, 64'd1);
    #3 reset = 1'b1;
    #1;
    check("ar_ready", {63'd0, tif.commit_ready}, 64'd1);
    check("ar_flush", {63'd0, tif.flush}, 64'd0);
    check("ar_cmd", {62'd0, tif.csr_ecall, tif.csr_mret}, 64'd0);
    check("ar_rv", {63'd0, tif.redirect_valid}, 64'd0);
    check("ar_cnt", {32'd0, tif.trap_count}, 64'd0);
    check("ar_err", {63'd0, tif.drain_error}, 64'd0);
    check("ar_csr_pc", tif.csr_pc, 64'd0);
    check("ar_rd_pc", tif.redirect_pc, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tif.mem_busy = 1'b0;
    exp_cnt = 0;
    repeat (10) @(negedge clk);
    check("ar_cnt_after", {32'd0, tif.trap_count}, 64'd0);
    check("ar_ready_after", {63'd0, tif.commit_ready}, 64'd1);

    run_trap(64'h9000, 1'b1, 1'b0, 64'h9104, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("isq_empty", 64'(isq.size()), 64'd0);
    check("rsq_empty", 64'(rsq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
